spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 serial-flash read responder.
// Serves READ (0x03 + address, streaming bytes from an external byte memory)
// and READ STATUS (0x05). All other commands are ignored.
// Build macro SPI_FLASH_JEDEC_ID_EN adds READ JEDEC ID (0x9F). Without it,
// 0x9F is ignored and no ID logic exists.
`timescale 1ns/1ps

module spi_flash_responder #(
   parameter int unsigned ADDR_W     = 24,
   parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
   parameter logic [7:0]  STATUS_VAL = 8'h00
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              spi_sck_i,
   input  logic              spi_cs_ni,
   input  logic              spi_mosi_i,
   output logic              spi_miso_o,
   output logic              spi_miso_oe_o,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              rd_active_o
);

   localparam int unsigned      CNT_W     = $clog2(ADDR_W);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DATA, STAT, JEDEC, IGNORE
   } state_e;

   logic sck_meta_q, sck_sync_q, sck_prev_q;
   logic cs_meta_q, cs_sync_q;
   logic mosi_meta_q, mosi_sync_q;
   logic [1:0] flush_q;
   logic sck_rise, sck_fall;

   state_e            state_q, state_d;
   logic              armed_q, armed_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-2:0] in_sr_q, in_sr_d;
   logic [ADDR_W-1:0] sh_in;
   logic [2:0]        byte_cnt_q, byte_cnt_d;
   logic              load_pend_q, load_pend_d;
   logic [7:0]        out_sr_q, out_sr_d;
   logic              oe_q, oe_d;
   logic              mem_en_q, mem_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              cap_pend_q, cap_pend_d;
   logic [7:0]        next_byte_q, next_byte_d;
   logic [7:0]        load_byte;
   logic              streaming;
`ifdef SPI_FLASH_JEDEC_ID_EN
   logic [1:0]        jedec_idx_q, jedec_idx_d;
`endif

   // Bring the asynchronous SPI pins into the clk_i domain and keep one SCK history bit.
   always_ff @(posedge clk_i) begin
      // NOTE: reset parks the synchronizers at a deselected bus (SCK=1, CS_N=1,
      // MOSI=0); flush_q marks when real pin values have reached the sync stage,
      // so those parked values can never arm the responder.
      if (!rst_i) begin
         sck_meta_q  <= 1'b1;
         sck_sync_q  <= 1'b1;
         sck_prev_q  <= 1'b1;
         cs_meta_q   <= 1'b1;
         cs_sync_q   <= 1'b1;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
         flush_q     <= 2'b00;
      end else begin
         sck_meta_q  <= spi_sck_i;
         sck_sync_q  <= sck_meta_q;
         sck_prev_q  <= sck_sync_q;
         cs_meta_q   <= spi_cs_ni;
         cs_sync_q   <= cs_meta_q;
         mosi_meta_q <= spi_mosi_i;
         mosi_sync_q <= mosi_meta_q;
         flush_q     <= {flush_q[0], 1'b1};
      end
   end

   assign sck_rise = sck_sync_q & ~sck_prev_q;
   assign sck_fall = ~sck_sync_q & sck_prev_q;
   assign sh_in    = {in_sr_q, mosi_sync_q};

`ifdef SPI_FLASH_JEDEC_ID_EN
   assign streaming = (state_q == DATA) || (state_q == STAT) || (state_q == JEDEC);
`else
   assign streaming = (state_q == DATA) || (state_q == STAT);
`endif

   // Select the byte loaded into the MISO shifter on the first SCK fall of each byte.
   always_comb begin
      load_byte = next_byte_q;
      if (state_q == STAT) load_byte = STATUS_VAL;
`ifdef SPI_FLASH_JEDEC_ID_EN
      if (state_q == JEDEC) begin
         case (jedec_idx_q)
            2'd0:    load_byte = JEDEC_ID[23:16];
            2'd1:    load_byte = JEDEC_ID[15:8];
            2'd2:    load_byte = JEDEC_ID[7:0];
            default: load_byte = 8'hFF;
         endcase
      end
`endif
   end

   // State register: every FSM and datapath register moves here.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_i) begin
         state_q     <= IDLE;
         armed_q     <= 1'b0;
         bit_cnt_q   <= '0;
         in_sr_q     <= '0;
         byte_cnt_q  <= '0;
         load_pend_q <= 1'b0;
         out_sr_q    <= 8'hFF;
         oe_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         cap_pend_q  <= 1'b0;
         next_byte_q <= '0;
`ifdef SPI_FLASH_JEDEC_ID_EN
         jedec_idx_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         bit_cnt_q   <= bit_cnt_d;
         in_sr_q     <= in_sr_d;
         byte_cnt_q  <= byte_cnt_d;
         load_pend_q <= load_pend_d;
         out_sr_q    <= out_sr_d;
         oe_q        <= oe_d;
         mem_en_q    <= mem_en_d;
         mem_addr_q  <= mem_addr_d;
         cap_pend_q  <= cap_pend_d;
         next_byte_q <= next_byte_d;
`ifdef SPI_FLASH_JEDEC_ID_EN
         jedec_idx_q <= jedec_idx_d;
`endif
      end
   end

   // Next-state logic: command/address shifting, MISO streaming and memory strobes.
   always_comb begin
      // NOTE: every _d starts at its hold value so no path can infer a latch.
      state_d     = state_q;
      armed_d     = armed_q | (flush_q[1] & cs_sync_q);
      bit_cnt_d   = bit_cnt_q;
      in_sr_d     = in_sr_q;
      byte_cnt_d  = byte_cnt_q;
      load_pend_d = load_pend_q;
      out_sr_d    = out_sr_q;
      oe_d        = oe_q;
      mem_en_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      cap_pend_d  = mem_en_q;
      next_byte_d = cap_pend_q ? mem_rdata_i : next_byte_q;
`ifdef SPI_FLASH_JEDEC_ID_EN
      jedec_idx_d = jedec_idx_q;
`endif

      if (cs_sync_q) begin
         state_d     = IDLE;
         bit_cnt_d   = '0;
         byte_cnt_d  = '0;
         load_pend_d = 1'b0;
         oe_d        = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               bit_cnt_d = '0;
               if (armed_q) state_d = CMD;
            end
            CMD: begin
               if (sck_rise) begin
                  in_sr_d   = sh_in[ADDR_W-2:0];
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == CMD_LAST) begin
                     bit_cnt_d  = '0;
                     byte_cnt_d = '0;
                     case (sh_in[7:0])
                        8'h03: state_d = ADDR;
                        8'h05: begin
                           state_d     = STAT;
                           load_pend_d = 1'b1;
                        end
`ifdef SPI_FLASH_JEDEC_ID_EN
                        8'h9F: begin
                           state_d     = JEDEC;
                           load_pend_d = 1'b1;
                           jedec_idx_d = 2'd0;
                        end
`endif
                        default: state_d = IGNORE;
                     endcase
                  end
               end
            end
            ADDR: begin
               if (sck_rise) begin
                  in_sr_d   = sh_in[ADDR_W-2:0];
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == ADDR_LAST) begin
                     bit_cnt_d   = '0;
                     byte_cnt_d  = '0;
                     mem_en_d    = 1'b1;
                     mem_addr_d  = sh_in;
                     load_pend_d = 1'b1;
                     state_d     = DATA;
                  end
               end
            end
            default: ;
         endcase

         if (streaming) begin
            if (sck_fall) begin
               oe_d = 1'b1;
               if (load_pend_q) begin
                  out_sr_d    = load_byte;
                  load_pend_d = 1'b0;
               end else begin
                  out_sr_d = {out_sr_q[6:0], 1'b1};
               end
            end
            if (sck_rise) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               if (byte_cnt_q == 3'd7) begin
                  load_pend_d = 1'b1;
                  if (state_q == DATA) begin
                     mem_en_d   = 1'b1;
                     mem_addr_d = mem_addr_q + 1'b1;
                  end
`ifdef SPI_FLASH_JEDEC_ID_EN
                  if (state_q == JEDEC && jedec_idx_q != 2'd3) jedec_idx_d = jedec_idx_q + 1'b1;
`endif
               end
            end
         end
      end
   end

   assign spi_miso_o    = oe_q ? out_sr_q[7] : 1'b1;
   assign spi_miso_oe_o = oe_q;
   assign mem_en_o      = mem_en_q;
   assign mem_addr_o    = mem_addr_q;
   assign rd_active_o   = (state_q == DATA);

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI transactions against a transaction-level
// model of the responder (expected byte stream and memory address list per command).
`timescale 1ns/1ps

module tb_spi_flash_responder;

   localparam int          HALF   = 4;            // SCK half period in clk_i cycles
   localparam logic [23:0] ID     = 24'hEF4018;
   localparam logic [7:0]  STATUS = 8'h00;

   logic        clk_i       = 1'b0;
   logic        rst_i       = 1'b0;
   logic        spi_sck_i   = 1'b0;
   logic        spi_cs_ni   = 1'b1;
   logic        spi_mosi_i  = 1'b0;
   logic [7:0]  mem_rdata_i = 8'h5A;
   logic        spi_miso_o;
   logic        spi_miso_oe_o;
   logic        mem_en_o;
   logic [23:0] mem_addr_o;
   logic        rd_active_o;

   always #5 clk_i = ~clk_i;

   spi_flash_responder #(
      .ADDR_W    (24),
      .JEDEC_ID  (ID),
      .STATUS_VAL(STATUS)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .spi_sck_i    (spi_sck_i),
      .spi_cs_ni    (spi_cs_ni),
      .spi_mosi_i   (spi_mosi_i),
      .spi_miso_o   (spi_miso_o),
      .spi_miso_oe_o(spi_miso_oe_o),
      .mem_en_o     (mem_en_o),
      .mem_addr_o   (mem_addr_o),
      .mem_rdata_i  (mem_rdata_i),
      .rd_active_o  (rd_active_o)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Transaction model: expected MISO bytes, SCK index where they start, expected strobes.
   bit   txn_on     = 1'b0;
   int   sck_idx    = 0;
   int   resp_start = -1;
   int   exp_bytes[$];
   int   exp_addrs[$];
   int   got_bytes[$];
   int   got_addrs[$];
   int   base_b     = 0;
   int   base_a     = 0;

   function automatic void model_txn(input logic [7:0] cmd, input logic [23:0] addr, input int n_sck);
      exp_bytes.delete();
      exp_addrs.delete();
      resp_start = -1;
      case (cmd)
         8'h03: begin
            resp_start = 32;
            for (int i = 0; i < 16; i++) exp_bytes.push_back(((int'(addr) + i) % 'h100_0000) & 255);
            if (n_sck >= 32)
               for (int j = 0; j <= (n_sck - 32) / 8; j++)
                  exp_addrs.push_back((int'(addr) + j) % 'h100_0000);
         end
         8'h05: begin
            resp_start = 8;
            for (int i = 0; i < 16; i++) exp_bytes.push_back(int'(STATUS));
         end
`ifdef SPI_FLASH_JEDEC_ID_EN
         8'h9F: begin
            resp_start = 8;
            exp_bytes.push_back(int'(ID[23:16]));
            exp_bytes.push_back(int'(ID[15:8]));
            exp_bytes.push_back(int'(ID[7:0]));
            for (int i = 0; i < 13; i++) exp_bytes.push_back(255);
         end
`endif
         default: resp_start = -1;
      endcase
   endfunction

   function automatic int get_byte(input int i);
      if (base_b + i < got_bytes.size()) return got_bytes[base_b + i];
      return -1;
   endfunction

   function automatic int get_addr(input int i);
      if (base_a + i < got_addrs.size()) return got_addrs[base_a + i];
      return -1;
   endfunction

   // Compare MISO/OE against the model at every SCK rise (the master's sample point).
   logic [7:0] rx_byte = 8'h00;
   always @(posedge spi_sck_i) begin
      int         k;
      logic [7:0] b;
      if (txn_on) begin
         if (resp_start >= 0 && sck_idx >= resp_start) begin
            k = sck_idx - resp_start;
            b = 8'(exp_bytes[k / 8]);
            check("miso_oe", spi_miso_oe_o, 1'b1);
            check($sformatf("miso_bit[%0d]", k), spi_miso_o, b[3'(7 - k % 8)]);
            rx_byte = {rx_byte[6:0], spi_miso_o};
            if (k % 8 == 7) got_bytes.push_back(int'(rx_byte));
         end else begin
            check("oe_quiet", spi_miso_oe_o, 1'b0);
         end
      end
   end

   // Per-cycle invariants and memory strobe capture.
   logic prev_en = 1'b0;
   always @(negedge clk_i) begin
      if (rst_i) begin
         if (!spi_miso_oe_o) check("miso_idle_high", spi_miso_o, 1'b1);
         if (mem_en_o) begin
            check("mem_en_gap", prev_en, 1'b0);
            check("mem_en_in_read", rd_active_o, 1'b1);
            got_addrs.push_back(int'(mem_addr_o));
         end
      end
      prev_en = mem_en_o;
   end

   // Byte memory: byte[n] = n[7:0], data valid only in the cycle after the strobe.
   logic        mem_pend  = 1'b0;
   logic [23:0] mem_paddr = '0;
   always @(negedge clk_i) begin
      mem_rdata_i = mem_pend ? mem_paddr[7:0] : 8'h5A;
      mem_pend    = mem_en_o;
      mem_paddr   = mem_addr_o;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic sck_bit(input logic b);
      spi_mosi_i = b;
      wait_clk(HALF);
      spi_sck_i = 1'b1;
      wait_clk(HALF);
      spi_sck_i = 1'b0;
      sck_idx++;
   endtask

   task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input int n_sck);
      model_txn(cmd, addr, n_sck);
      base_b    = got_bytes.size();
      base_a    = got_addrs.size();
      sck_idx   = 0;
      txn_on    = 1'b1;
      spi_cs_ni = 1'b0;
      wait_clk(6);
      for (int i = 0; i < n_sck; i++) begin
         if (i < 8) sck_bit(cmd[3'(7 - i)]);
         else if (cmd == 8'h03 && i < 32) sck_bit(addr[5'(31 - i)]);
         else sck_bit(1'b0);
      end
   endtask

   task automatic cs_end();
      wait_clk(HALF);
      spi_cs_ni = 1'b1;
      txn_on    = 1'b0;
      wait_clk(8);
      check("oe_after_cs", spi_miso_oe_o, 1'b0);
      check("idle_after_cs", rd_active_o, 1'b0);
   endtask

   task automatic check_addrs(input string tag);
      check({tag, "_addr_count"}, got_addrs.size() - base_a, exp_addrs.size());
      for (int i = 0; i < exp_addrs.size(); i++)
         check($sformatf("%s_mem_addr[%0d]", tag, i), get_addr(i), exp_addrs[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"}, spi_miso_o, 1'b1);
      check({tag, "_oe"}, spi_miso_oe_o, 1'b0);
      check({tag, "_mem_en"}, mem_en_o, 1'b0);
      check({tag, "_mem_addr"}, mem_addr_o, 24'h0);
      check({tag, "_rd_active"}, rd_active_o, 1'b0);
   endtask

   initial begin
      wait_clk(3);
      check_reset_outputs("reset");
      rst_i = 1'b1;
      wait_clk(4);

      // READ 0x000100, three data bytes
      run_txn(8'h03, 24'h000100, 32 + 24);
      cs_end();
      check_addrs("read100");
      check("read100_nbytes", got_bytes.size() - base_b, 3);
      check("read100_byte0", get_byte(0), 8'h00);
      check("read100_byte1", get_byte(1), 8'h01);
      check("read100_byte2", get_byte(2), 8'h02);
      check("read100_addr3", get_addr(3), 24'h000103);

      // READ at the top of the address space wraps to 0
      run_txn(8'h03, 24'hFFFFFF, 32 + 16);
      cs_end();
      check_addrs("wrap");
      check("wrap_addr1", get_addr(1), 24'h000000);
      check("wrap_byte0", get_byte(0), 8'hFF);
      check("wrap_byte1", get_byte(1), 8'h00);

      // READ STATUS, two bytes
      run_txn(8'h05, 24'h0, 8 + 16);
      cs_end();
      check_addrs("stat");
      check("stat_nbytes", got_bytes.size() - base_b, 2);
      check("stat_byte1", get_byte(1), 8'h00);

      // READ JEDEC ID, four bytes
      run_txn(8'h9F, 24'h0, 8 + 32);
      cs_end();
      check_addrs("jedec");
`ifdef SPI_FLASH_JEDEC_ID_EN
      check("jedec_byte0", get_byte(0), 8'hEF);
      check("jedec_byte1", get_byte(1), 8'h40);
      check("jedec_byte2", get_byte(2), 8'h18);
      check("jedec_byte3", get_byte(3), 8'hFF);
`else
      check("jedec_off_nbytes", got_bytes.size() - base_b, 0);
`endif

      // Unsupported command followed by 40 SCK
      run_txn(8'hAB, 24'h0, 8 + 40);
      cs_end();
      check_addrs("ignore");
      check("ignore_no_mem", got_addrs.size() - base_a, 0);

      // CS_N raised after 12 address bits, then a clean READ at 0x000010
      run_txn(8'h03, 24'h000010, 8 + 12);
      cs_end();
      check_addrs("abort");
      run_txn(8'h03, 24'h000010, 32 + 16);
      cs_end();
      check_addrs("post_abort");
      check("post_abort_byte0", get_byte(0), 8'h10);
      check("post_abort_byte1", get_byte(1), 8'h11);

      // Reset pulse mid-DATA with CS_N held low
      run_txn(8'h03, 24'h000040, 32 + 12);
      check("pre_reset_rd_active", rd_active_o, 1'b1);
      check("pre_reset_byte0", get_byte(0), 8'h40);
      rst_i = 1'b0;
      wait_clk(1);
      rst_i = 1'b1;
      check_reset_outputs("mid_reset");
      resp_start = -1;
      for (int i = 0; i < 16; i++) sck_bit(1'b0);
      check("mid_reset_rd_active", rd_active_o, 1'b0);
      cs_end();
      check_addrs("mid_reset");
      run_txn(8'h03, 24'h000020, 32 + 8);
      cs_end();
      check_addrs("after_reset");
      check("after_reset_byte0", get_byte(0), 8'h20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
